// File: rtl/vec_proc_pkg.sv
// Shared definitions for the vector-processor result path: operation
// indices on the one-hot enables bus, per-operation byte counts, result
// width helpers and the result serializer state encoding.
package vec_proc_pkg;

    // Bit positions of each operation on the enables bus
    typedef enum int {
        OP_READ = 0,
        OP_SUM  = 1,
        OP_AVG  = 2,
        OP_EUC  = 3,
        OP_MAN  = 4,
        OP_DOT  = 5
    } op_idx_t;

    localparam int NUM_OPS = 6;
    localparam int SHIFT_W = 32;

    // Bytes sent on the UART for each operation's result
    localparam logic [2:0] BYTES_READ = 3'd1;
    localparam logic [2:0] BYTES_SUM  = 3'd2;
    localparam logic [2:0] BYTES_AVG  = 3'd1;
    localparam logic [2:0] BYTES_EUC  = 3'd2;
    localparam logic [2:0] BYTES_MAN  = 3'd3;
    localparam logic [2:0] BYTES_DOT  = 3'd4;

    // Manhattan distance grows by one bit per doubling of the vector length
    function automatic int man_width(input int num_elem);
        return 8 + $clog2(num_elem);
    endfunction

    // Dot product of 8-bit elements accumulates into a 16-bit base
    function automatic int dot_width(input int num_elem);
        return 16 + $clog2(num_elem);
    endfunction

    // Place an n-byte result at the top of a 32-bit word so bytes leave MSB first
    function automatic logic [31:0] msb_align(input logic [31:0] value, input logic [2:0] nbytes);
        return value << (8 * (4 - int'(nbytes)));
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_FREE,
        ST_LAUNCH,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } ser_state_t;

endpackage

// File: rtl/result_tx_serializer_mux.sv
// result_select_mux: picks the result of the lowest set enables bit,
// zero-extends it to its byte count and MSB-aligns it in a 32-bit word.
// enables == 0 yields an empty word and a byte count of zero.
module result_select_mux
    import vec_proc_pkg::*;
#(
    parameter int MAN_W = 18,
    parameter int DOT_W = 26
) (
    input  logic [5:0]       enables,
    input  logic [7:0]       res_read,
    input  logic [8:0]       res_sum,
    input  logic [7:0]       res_avg,
    input  logic [15:0]      res_euc,
    input  logic [MAN_W-1:0] res_man,
    input  logic [DOT_W-1:0] res_dot,
    output logic [31:0]      sel_word,
    output logic [2:0]       sel_count
);

    // Priority select: lower enables bits win when more than one is set
    always_comb begin
        sel_word  = '0;
        sel_count = '0;
        if (enables[OP_READ]) begin
            sel_word  = msb_align(32'(res_read), BYTES_READ);
            sel_count = BYTES_READ;
        end else if (enables[OP_SUM]) begin
            sel_word  = msb_align(32'(res_sum), BYTES_SUM);
            sel_count = BYTES_SUM;
        end else if (enables[OP_AVG]) begin
            sel_word  = msb_align(32'(res_avg), BYTES_AVG);
            sel_count = BYTES_AVG;
        end else if (enables[OP_EUC]) begin
            sel_word  = msb_align(32'(res_euc), BYTES_EUC);
            sel_count = BYTES_EUC;
        end else if (enables[OP_MAN]) begin
            sel_word  = msb_align(32'(res_man), BYTES_MAN);
            sel_count = BYTES_MAN;
        end else if (enables[OP_DOT]) begin
            sel_word  = msb_align(32'(res_dot), BYTES_DOT);
            sel_count = BYTES_DOT;
        end
    end

endmodule

// File: rtl/result_tx_serializer.sv
// result_tx_serializer: snapshots the selected operation result on tx_start
// and streams it big-endian through the UART byte handshake, then pulses
// tx_sent. Optional macro TX_CHECKSUM_EN appends one XOR checksum byte
// after the result bytes.
module result_tx_serializer
    import vec_proc_pkg::*;
#(
    parameter int  NUM_ELEMENTOS = 1024,
    parameter int  BYTE_W        = 8,     // UART payload width, must stay 8
    localparam int MAN_W         = man_width(NUM_ELEMENTOS),
    localparam int DOT_W         = dot_width(NUM_ELEMENTOS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_start,
    input  logic [5:0]        enables,
    input  logic [7:0]        res_read,
    input  logic [8:0]        res_sum,
    input  logic [7:0]        res_avg,
    input  logic [15:0]       res_euc,
    input  logic [MAN_W-1:0]  res_man,
    input  logic [DOT_W-1:0]  res_dot,
    input  logic              uart_tx_busy,
    output logic [BYTE_W-1:0] uart_tx_data,
    output logic              uart_tx_start,
    output logic              tx_sent,
    output logic              ser_busy
);

    ser_state_t  state_reg, state_next;
    logic [31:0] shift_reg;
    logic [2:0]  count_reg;
    logic [7:0]  data_reg;
    logic [31:0] sel_word;
    logic [2:0]  sel_count;
`ifdef TX_CHECKSUM_EN
    logic [7:0]  chk_reg;
`endif

    result_select_mux #(
        .MAN_W(MAN_W),
        .DOT_W(DOT_W)
    ) u_mux (
        .enables  (enables),
        .res_read (res_read),
        .res_sum  (res_sum),
        .res_avg  (res_avg),
        .res_euc  (res_euc),
        .res_man  (res_man),
        .res_dot  (res_dot),
        .sel_word (sel_word),
        .sel_count(sel_count)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; an empty request (count 0) skips the byte loop
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (tx_start) state_next = ST_LOAD;
            ST_LOAD:      state_next = (count_reg == 3'd0) ? ST_DONE : ST_WAIT_FREE;
            ST_WAIT_FREE: if (!uart_tx_busy) state_next = ST_LAUNCH;
            ST_LAUNCH:    state_next = ST_WAIT_HI;
            ST_WAIT_HI:   if (uart_tx_busy) state_next = ST_WAIT_LO;
            ST_WAIT_LO:   if (!uart_tx_busy) state_next = (count_reg == 3'd1) ? ST_DONE : ST_WAIT_FREE;
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Status and handshake outputs decoded from the state
    always_comb begin
        uart_tx_start = (state_reg == ST_LAUNCH);
        tx_sent       = (state_reg == ST_DONE);
        ser_busy      = (state_reg != ST_IDLE);
    end

    assign uart_tx_data = BYTE_W'(data_reg);

    // Snapshot, byte output register and shifting; the output byte is
    // captured on entry to LAUNCH so it holds until the next launch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            count_reg <= '0;
            data_reg  <= '0;
`ifdef TX_CHECKSUM_EN
            chk_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (tx_start) begin
                        shift_reg <= sel_word;
`ifdef TX_CHECKSUM_EN
                        count_reg <= sel_count + 3'd1;
                        chk_reg   <= '0;
`else
                        count_reg <= sel_count;
`endif
                    end
                end
                ST_WAIT_FREE: begin
                    if (!uart_tx_busy) begin
                        data_reg <= shift_reg[31:24];
`ifdef TX_CHECKSUM_EN
                        chk_reg  <= chk_reg ^ shift_reg[31:24];
`endif
                    end
                end
                ST_WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        count_reg <= count_reg - 3'd1;
`ifdef TX_CHECKSUM_EN
                        // Last result byte just left: queue the checksum next
                        if (count_reg == 3'd2) shift_reg <= {chk_reg, 24'h0};
                        else                   shift_reg <= shift_reg << 8;
`else
                        shift_reg <= shift_reg << 8;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
